shake_arbiter: RTL and testbench

Time-shares the single SHAKE core (32-bit din/dout valid-ready stream) between NUM_REQ requesters, each needing a 128-bit digest of a 128-bit message (key derivation, encryption-seed generation).
Arbitration is round-robin. The granted message is framed as length header plus four data words, and the 128-bit output is read back and byte-swapped. The digest is returned to the winner with a one-cycle completion pulse.
Sits between the main controller / crypto engines and the SHAKE core.

---
 rtl/shake_ctrl_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/shake_arbiter.sv | 150 +++++++++++++++
 tb/tb_shake_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shake_ctrl_pkg.sv
// rtl/shake_ctrl_pkg.sv - SHAKE framing constants, FSM encoding and word helpers
package shake_ctrl_pkg;

    localparam logic [31:0] SHAKE_OLEN_128   = 32'h0000_0080;
    localparam logic [31:0] SHAKE_ILEN_128   = 32'h8000_0080;
    localparam int          SHAKE_DATA_WORDS = 4;
    localparam int          SHAKE_OUT_WORDS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_READ,
        ST_RESP
    } shake_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Beat order on din: output length, input length, then message MSW first.
    function automatic logic [31:0] send_word(input logic [2:0] idx, input logic [127:0] msg);
        case (idx)
            3'd0:    return SHAKE_OLEN_128;
            3'd1:    return SHAKE_ILEN_128;
            3'd2:    return msg[127:96];
            3'd3:    return msg[95:64];
            3'd4:    return msg[63:32];
            3'd5:    return msg[31:0];
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - N-wide round-robin arbiter, pointer advances to the winner on en
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         any
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] lo_idx, hi_idx, win_idx;
    logic          lo_any, hi_any;

    // Lowest requester above the pointer wins; otherwise wrap to the lowest overall.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        lo_any = 1'b0;
        hi_any = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx = IW'(j);
                lo_any = 1'b1;
            end
            if (req[j] && (j > int'(ptr))) begin
                hi_idx = IW'(j);
                hi_any = 1'b1;
            end
        end
        win_idx = hi_any ? hi_idx : lo_idx;
        any     = lo_any;
        gnt     = lo_any ? (N'(1) << win_idx) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= IW'(N - 1);
        end else if (en && lo_any) begin
            ptr <= win_idx;
        end
    end

endmodule

// File: rtl/shake_arbiter.sv
// rtl/shake_arbiter.sv - round-robin time-sharing of one SHAKE core for 128-bit digests
// Optional watchdog abort enabled by SHAKE_TIMEOUT_EN.
module shake_arbiter
    import shake_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*128-1:0] req_msg,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [127:0]           rsp_digest,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   din_valid,
    output logic [31:0]            din,
    input  logic                   din_ready,
    input  logic                   dout_valid,
    input  logic [31:0]            dout,
    output logic                   dout_ready
);

    shake_state_t       state;
    logic [127:0]       msg;
    logic [127:0]       digest;
    logic [2:0]         word_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_any;
    logic [127:0]       sel_msg;

`ifdef SHAKE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] to_cnt;
    logic            to_err;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign rsp_err = 1'b0;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clock (clock),
        .reset (reset),
        .en    (state == ST_IDLE),
        .req   (req),
        .gnt   (arb_gnt),
        .any   (arb_any)
    );

    always_comb begin
        sel_msg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) sel_msg = req_msg[i*128 +: 128];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            rsp_valid  <= '0;
            rsp_digest <= '0;
            busy       <= 1'b0;
            din_valid  <= 1'b0;
            din        <= '0;
            dout_ready <= 1'b0;
            msg        <= '0;
            digest     <= '0;
            word_cnt   <= '0;
`ifdef SHAKE_TIMEOUT_EN
            rsp_err    <= 1'b0;
            to_cnt     <= '0;
            to_err     <= 1'b0;
`endif
        end else begin
            rsp_valid <= '0;
`ifdef SHAKE_TIMEOUT_EN
            rsp_err <= 1'b0;
            if (state == ST_SEND || state == ST_READ) to_cnt <= to_cnt + TO_W'(1);
`endif
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant     <= arb_gnt;
                        msg       <= sel_msg;
                        digest    <= '0;
                        word_cnt  <= '0;
                        busy      <= 1'b1;
                        din_valid <= 1'b1;
                        din       <= send_word(3'd0, sel_msg);
                        state     <= ST_SEND;
`ifdef SHAKE_TIMEOUT_EN
                        to_cnt    <= '0;
                        to_err    <= 1'b0;
`endif
                    end
                end
                ST_SEND: begin
                    if (din_valid && din_ready) begin
                        if (word_cnt == 3'(SHAKE_DATA_WORDS + 1)) begin
                            din_valid  <= 1'b0;
                            dout_ready <= 1'b1;
                            word_cnt   <= '0;
                            state      <= ST_READ;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                            din      <= send_word(word_cnt + 3'd1, msg);
                        end
                    end
                end
                ST_READ: begin
                    if (dout_valid && dout_ready) begin
                        digest <= {digest[95:0], bswap32(dout)};
                        if (word_cnt == 3'(SHAKE_OUT_WORDS - 1)) begin
                            dout_ready <= 1'b0;
                            state      <= ST_RESP;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end
                ST_RESP: begin
                    rsp_valid  <= grant;
                    grant      <= '0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
`ifdef SHAKE_TIMEOUT_EN
                    rsp_err    <= to_err;
                    rsp_digest <= to_err ? '0 : digest;
`else
                    rsp_digest <= digest;
`endif
                end
                default: state <= ST_IDLE;
            endcase
`ifdef SHAKE_TIMEOUT_EN
            // Watchdog overrides whatever SEND/READ decided this cycle.
            if ((state == ST_SEND || state == ST_READ) && to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                state      <= ST_RESP;
                din_valid  <= 1'b0;
                dout_ready <= 1'b0;
                to_err     <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_shake_arbiter.sv
// tb/tb_shake_arbiter.sv - directed self-checking bench for shake_arbiter (SHAKE_TIMEOUT_EN optional)
module tb_shake_arbiter;

    localparam int N = 2;
    localparam logic [127:0] MSG0    = 128'h12345678_87654321_11111111_00000000;
    localparam logic [127:0] MSG1    = 128'hCAFEF00D_DEADBEEF_01020304_A5A5A5A5;
    localparam logic [127:0] EXP_DIG = 128'hDDCCBBAA_44332211_88776655_CCBBAA99;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*128-1:0] req_msg = {MSG1, MSG0};
    logic [N-1:0]     grant, rsp_valid;
    logic [127:0]     rsp_digest;
    logic             rsp_err, busy, din_valid, dout_ready;
    logic [31:0]      din;
    logic             din_ready = 1'b1;
    logic             dout_valid = 1'b0;
    logic [31:0]      dout = '0;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [31:0] din_log[$];
    logic [31:0] out_words[4] = '{32'hAABBCCDD, 32'h11223344, 32'h55667788, 32'h99AABBCC};
    logic [31:0] exp_words[6] = '{32'h00000080, 32'h80000080, 32'h12345678, 32'h87654321,
                                  32'h11111111, 32'h00000000};
    int          out_idx = 0;
    bit          bp_mode = 0;
    bit          sparse_mode = 0;
    logic        din_ready_hold = 1'b1;
    bit          stall_pending = 0;
    logic [31:0] stall_din = '0;
    int          cyc;
    logic [N-1:0] gnt_seen;
    bit          two_hot;
    logic [127:0] held_digest;

    shake_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_msg    (req_msg),
        .grant      (grant),
        .rsp_valid  (rsp_valid),
        .rsp_digest (rsp_digest),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the SHAKE core model: drive handshakes at negedge, log the beats
    // that will transfer at the coming posedge, and police din stability under stall.
    task automatic cycle();
        @(negedge clock);
        if (stall_pending) begin
            chk("din_valid_held", din_valid, 1'b1);
            chk("din_stable", din, stall_din);
        end
        if (!busy) out_idx = 0;
        din_ready  = bp_mode ? ($urandom_range(0, 1) == 1) : din_ready_hold;
        dout_valid = sparse_mode ? ($urandom_range(0, 2) == 0) : 1'b1;
        dout       = out_words[out_idx % 4];
        stall_pending = din_valid && !din_ready && !reset;
        stall_din     = din;
        if (din_valid && din_ready && !reset) din_log.push_back(din);
        if (dout_valid && dout_ready && !reset) out_idx++;
    endtask

    task automatic wait_rsp(input int budget, output int n, output logic [N-1:0] g, output bit th);
        n = 0;
        g = '0;
        th = 0;
        do begin
            cycle();
            n++;
            if (grant != '0) g = grant;
            if ($countones(grant) > 1) th = 1;
        end while (rsp_valid == '0 && n < budget);
    endtask

    initial begin
        repeat (3) cycle();
        chk("rst_grant", grant, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_digest", rsp_digest, '0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_din_valid", din_valid, 1'b0);
        chk("rst_din", din, '0);
        chk("rst_dout_ready", dout_ready, 1'b0);
        reset = 1'b0;
        cycle();

        // Single request, no backpressure
        din_log.delete();
        req = 2'b01;
        cycle();
        chk("t1_grant", grant, 2'b01);
        chk("t1_busy", busy, 1'b1);
        chk("t1_din_valid", din_valid, 1'b1);
        chk("t1_din_first", din, 32'h80);
        wait_rsp(100, cyc, gnt_seen, two_hot);
        chk("t1_latency", cyc, 11);
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_digest", rsp_digest, EXP_DIG);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_grant_clr", grant, '0);
        chk("t1_din_count", din_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t1_din_w%0d", i), din_log[i], exp_words[i]);
        req = 2'b00;
        cycle();
        chk("t1_pulse_once", rsp_valid, '0);
        chk("t1_digest_hold", rsp_digest, EXP_DIG);

        // Random din_ready and sparse dout_valid
        din_log.delete();
        bp_mode = 1;
        sparse_mode = 1;
        req = 2'b01;
        wait_rsp(300, cyc, gnt_seen, two_hot);
        chk("t2_rsp_valid", rsp_valid, 2'b01);
        chk("t2_digest", rsp_digest, EXP_DIG);
        chk("t2_din_count", din_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_din_w%0d", i), din_log[i], exp_words[i]);
        req = 2'b00;
        bp_mode = 0;
        sparse_mode = 0;
        cycle();

        // Reset in READ after two dout beats
        req = 2'b01;
        cyc = 0;
        do begin
            cycle();
            cyc++;
        end while (out_idx < 2 && cyc < 100);
        cycle();
        chk("t3_in_read", dout_ready, 1'b1);
        reset = 1'b1;
        req = 2'b00;
        cycle();
        chk("t3_grant", grant, '0);
        chk("t3_rsp_valid", rsp_valid, '0);
        chk("t3_rsp_digest", rsp_digest, '0);
        chk("t3_busy", busy, 1'b0);
        chk("t3_din_valid", din_valid, 1'b0);
        chk("t3_din", din, '0);
        chk("t3_dout_ready", dout_ready, 1'b0);
        din_log.delete();
        reset = 1'b0;
        req = 2'b01;
        wait_rsp(100, cyc, gnt_seen, two_hot);
        chk("t3_after_rsp_valid", rsp_valid, 2'b01);
        chk("t3_after_digest", rsp_digest, EXP_DIG);
        chk("t3_after_din_count", din_log.size(), 6);
        req = 2'b00;
        cycle();

        // Requester drops req during SEND
        req = 2'b01;
        cycle();
        cycle();
        chk("t4_in_send", din_valid, 1'b1);
        req = 2'b00;
        wait_rsp(100, cyc, gnt_seen, two_hot);
        chk("t4_rsp_valid", rsp_valid, 2'b01);
        chk("t4_digest", rsp_digest, EXP_DIG);
        repeat (4) cycle();
        chk("t4_idle_grant", grant, '0);
        chk("t4_idle_busy", busy, 1'b0);

        // Contention from a fresh reset: 0,1,0,1
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req = 2'b11;
        din_log.delete();
        for (int k = 0; k < 4; k++) begin
            wait_rsp(100, cyc, gnt_seen, two_hot);
            chk($sformatf("t5_rsp_valid_%0d", k), rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t5_grant_%0d", k), gnt_seen, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t5_onehot_%0d", k), two_hot, 1'b0);
            chk($sformatf("t5_period_%0d", k), cyc, 12);
            chk($sformatf("t5_digest_%0d", k), rsp_digest, EXP_DIG);
            chk($sformatf("t5_din_count_%0d", k), din_log.size(), 6);
            chk($sformatf("t5_msg_word_%0d", k), din_log[2], (k % 2 == 0) ? MSG0[127:96] : MSG1[127:96]);
            din_log.delete();
        end
        req = 2'b00;
        cycle();

`ifdef SHAKE_TIMEOUT_EN
        // Watchdog with din_ready stuck low
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        din_ready_hold = 1'b0;
        req = 2'b01;
        wait_rsp(200, cyc, gnt_seen, two_hot);
        chk("t6_latency", cyc, 67);
        chk("t6_rsp_valid", rsp_valid, 2'b01);
        chk("t6_rsp_err", rsp_err, 1'b1);
        chk("t6_digest", rsp_digest, '0);
        chk("t6_din_valid", din_valid, 1'b0);
        chk("t6_dout_ready", dout_ready, 1'b0);
        req = 2'b00;
        din_ready_hold = 1'b1;
        cycle();
        chk("t6_err_pulse", rsp_err, 1'b0);
`endif

        held_digest = rsp_digest;
        cycle();
        chk("final_idle", busy, 1'b0);
        chk("final_digest_hold", rsp_digest, held_digest);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
